enter_prompt_ctrl: RTL
======================

// Module: enter_prompt_ctrl
// PURPOSE
// Title-screen sequencer for the "ENTER" prompt bitmap (51x15 sprite, 8-bit RGB, 0x00 transparent).
// - Converts raster pixelX/pixelY into the prompt's InsideRectangle/offsetX/offsetY.
// - Blinks the prompt and debounces the Enter key, both frame-based.
// - Emits a one-cycle startGame pulse, hides the prompt during play, re-arms on gameOver.
// Sits between the VGA raster counter / keyboard decoder and the prompt bitmap drawer.
// PARAMETERS
// TOP_LEFT_X        294  prompt left column (pixels)
// TOP_LEFT_Y        300  prompt top row (pixels)
// OBJECT_WIDTH_X    51   prompt width (pixels)
// OBJECT_HEIGHT_Y   15   prompt height (pixels)
// BLINK_FRAMES      30   frames per blink half-period (>=1)
// DEBOUNCE_FRAMES   4    consecutive frames a key level must hold (>=1)
// CONFIRM_FRAMES    60   frames prompt is held solid after accepted press (>=1)
// PORTS
// clk              in   1   system/pixel clock
// reset            in   1   asynchronous, active-high reset
// pixelX           in   11  current raster column
// pixelY           in   11  current raster row
// startOfFrame     in   1   one-cycle pulse, first pixel of each frame
// enterKey         in   1   Enter key level, already synchronous to clk
// gameOver         in   1   one-cycle pulse from game logic
// InsideRectangle  out  1   pixel lies in prompt box AND prompt visible
// offsetX          out  11  pixelX - TOP_LEFT_X when inside, else 0
// offsetY          out  11  pixelY - TOP_LEFT_Y when inside, else 0
// startGame        out  1   one-cycle pulse on entry to PLAY
// titleActive      out  1   high in all states except PLAY
// BEHAVIOUR
// Reset: state=WAIT_RELEASE, blinkPhase=1, blinkCnt=0, debCnt=0, confCnt=0; outputs
//   InsideRectangle=0, offsetX=0, offsetY=0, startGame=0, titleActive=1.
// Reset asserted mid-operation aborts any state/count; startGame never emitted during or on exit from reset.
// Geometry: in box iff TOP_LEFT_X<=pixelX<TOP_LEFT_X+OBJECT_WIDTH_X and same for Y
//   (unsigned, 12-bit compare, no wrap).
// Outputs registered: InsideRectangle/offsetX/offsetY are valid 1 clk after pixelX/Y
//   (drawer adds 1 more -> RGB at +2; raster mux compensates).
// Visibility: WAIT_RELEASE/TITLE -> blinkPhase; CONFIRM -> always 1; PLAY -> 0.
// Blink: on startOfFrame, blinkCnt++; at BLINK_FRAMES-1 -> blinkCnt=0, blinkPhase toggles.
//   Counts in every state; forced to blinkPhase=1, blinkCnt=0 on entry to WAIT_RELEASE.
// Key sampling only on startOfFrame cycles; debCnt saturates at DEBOUNCE_FRAMES.
// FSM (transitions evaluated on startOfFrame unless noted):
//   WAIT_RELEASE: enterKey==0 -> debCnt++, else debCnt=0;
//     debCnt reaches DEBOUNCE_FRAMES -> TITLE, debCnt=0.
//   TITLE: enterKey==1 -> debCnt++, else debCnt=0;
//     reaches DEBOUNCE_FRAMES -> CONFIRM, confCnt=0.
//   CONFIRM: confCnt++; at CONFIRM_FRAMES-1 -> PLAY.
//     Key ignored; startGame=1 for the single clk the state becomes PLAY.
//   PLAY: gameOver (any cycle) -> WAIT_RELEASE next clk, debCnt=0.
// gameOver outside PLAY: ignored.
// gameOver coincident with startOfFrame in PLAY: gameOver wins; blink/deb restart as on entry.
// A key held through gameOver cannot restart play: must be released DEBOUNCE_FRAMES frames first.
// startGame and titleActive are registered; titleActive falls in the same clk startGame rises.
// Counter widths: $clog2(param+1); no counter wraps beyond its terminal value.
// TESTING
// 1 Reset mid-CONFIRM -> next clk state WAIT_RELEASE, startGame=0, all outputs at reset values.
// 2 pixel=(294,300) -> +1 clk Inside=1, off=(0,0); (344,314) -> off=(50,14); (345,300),(294,315) -> Inside=0, off=0.
// 3 Key low, 30 frames -> prompt visible frames 0-29, hidden 30-59, visible 60+ (phase checked at pixel (300,305)).
// 4 Key high 3 frames then low 1 frame -> stay TITLE; then high 4 frames -> CONFIRM, prompt solid 60 frames,
//   then exactly one startGame pulse.
// 5 In PLAY, gameOver with key held -> WAIT_RELEASE; key held 100 frames -> no startGame;
//   release 4 frames, press 4 -> CONFIRM.
// 6 gameOver pulsed in TITLE and CONFIRM -> no state change; gameOver on startOfFrame in PLAY -> WAIT_RELEASE, blinkPhase=1.

Source files
------------

// File: rtl/enter_prompt_ctrl_if.sv
// ---------------------------------------------------------------------------
// enter_prompt_ctrl_if
// Signal bundle between the title-screen prompt sequencer and its neighbours
// (VGA raster counter, keyboard decoder, game logic, prompt bitmap drawer).
//
//   pixelX, pixelY   11  current raster column / row
//   startOfFrame      1  one-cycle pulse on the first pixel of each frame
//   enterKey          1  Enter key level, synchronous to clk
//   gameOver          1  one-cycle pulse from game logic
//   InsideRectangle   1  pixel lies in the prompt box and the prompt is shown
//   offsetX, offsetY 11  pixel position relative to the prompt's top-left
//   startGame         1  one-cycle pulse when play begins
//   titleActive       1  high whenever the game is not being played
//
// Modports:
//   master - the environment side: drives raster/key/game inputs
//   slave  - the sequencer side: drives prompt geometry and game control
// ---------------------------------------------------------------------------
interface enter_prompt_ctrl_if;
   logic [10:0] pixelX;
   logic [10:0] pixelY;
   logic        startOfFrame;
   logic        enterKey;
   logic        gameOver;
   logic        InsideRectangle;
   logic [10:0] offsetX;
   logic [10:0] offsetY;
   logic        startGame;
   logic        titleActive;

   modport master (
      output pixelX, pixelY, startOfFrame, enterKey, gameOver,
      input  InsideRectangle, offsetX, offsetY, startGame, titleActive
   );

   modport slave (
      input  pixelX, pixelY, startOfFrame, enterKey, gameOver,
      output InsideRectangle, offsetX, offsetY, startGame, titleActive
   );
endinterface

// File: rtl/enter_prompt_ctrl.sv
// ---------------------------------------------------------------------------
// enter_prompt_ctrl
// Title-screen sequencer for the "ENTER" prompt bitmap (51x15 sprite).
//   - Maps the raster position onto the prompt box and reports the offset
//     inside it, so the bitmap drawer can fetch the right texel.
//   - Blinks the prompt and debounces the Enter key, both counted in frames.
//   - Emits a one-cycle startGame pulse, hides the prompt during play and
//     re-arms the title screen when the game reports gameOver.
//
// Ports:
//   clk    in  system / pixel clock
//   reset  in  asynchronous, active-high reset
//   bus    slave side of enter_prompt_ctrl_if:
//            in : pixelX, pixelY, startOfFrame, enterKey, gameOver
//            out: InsideRectangle, offsetX, offsetY, startGame, titleActive
//
// All outputs are registered. The geometry outputs describe the pixel that
// was presented one clock earlier; the drawer adds one more stage, and the
// raster mux compensates for the total of two.
//
// State flow:
//   WAIT_RELEASE : key must be seen released on DEBOUNCE_FRAMES consecutive
//                  frames, so a key held through gameOver cannot restart play.
//   TITLE        : key must be seen pressed on DEBOUNCE_FRAMES consecutive
//                  frames.
//   CONFIRM      : prompt shown solid for CONFIRM_FRAMES frames, key ignored.
//   PLAY         : prompt hidden until gameOver.
// ---------------------------------------------------------------------------
module enter_prompt_ctrl #(
   parameter int unsigned TOP_LEFT_X      = 294,
   parameter int unsigned TOP_LEFT_Y      = 300,
   parameter int unsigned OBJECT_WIDTH_X  = 51,
   parameter int unsigned OBJECT_HEIGHT_Y = 15,
   parameter int unsigned BLINK_FRAMES    = 30,
   parameter int unsigned DEBOUNCE_FRAMES = 4,
   parameter int unsigned CONFIRM_FRAMES  = 60
) (
   input  logic                clk,
   input  logic                reset,
   enter_prompt_ctrl_if.slave  bus
);

   // ------------------------------------------------------------------------
   // Constants
   // ------------------------------------------------------------------------
   localparam int BLINK_W = $clog2(BLINK_FRAMES + 1);
   localparam int DEB_W   = $clog2(DEBOUNCE_FRAMES + 1);
   localparam int CONF_W  = $clog2(CONFIRM_FRAMES + 1);

   // Box bounds are compared at 12 bits so that TOP_LEFT + SIZE never wraps.
   localparam logic [11:0] X_LO = 12'(TOP_LEFT_X);
   localparam logic [11:0] X_HI = 12'(TOP_LEFT_X + OBJECT_WIDTH_X);
   localparam logic [11:0] Y_LO = 12'(TOP_LEFT_Y);
   localparam logic [11:0] Y_HI = 12'(TOP_LEFT_Y + OBJECT_HEIGHT_Y);
   localparam logic [10:0] X_ORG = 11'(TOP_LEFT_X);
   localparam logic [10:0] Y_ORG = 11'(TOP_LEFT_Y);

   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);
   localparam logic [DEB_W-1:0]   DEB_DONE   = DEB_W'(DEBOUNCE_FRAMES);
   localparam logic [CONF_W-1:0]  CONF_LAST  = CONF_W'(CONFIRM_FRAMES - 1);

   typedef enum logic [1:0] {
      WAIT_RELEASE = 2'd0,
      TITLE        = 2'd1,
      CONFIRM      = 2'd2,
      PLAY         = 2'd3
   } state_t;

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   state_t               state;
   logic                 blink_phase;
   logic [BLINK_W-1:0]   blink_cnt;
   logic [DEB_W-1:0]     deb_cnt;
   logic [CONF_W-1:0]    conf_cnt;

   // ------------------------------------------------------------------------
   // Combinational helpers
   // ------------------------------------------------------------------------
   logic [11:0]          px_ext;
   logic [11:0]          py_ext;
   logic                 in_box;
   logic                 visible;
   logic                 shown;
   logic [DEB_W-1:0]     deb_inc;

   assign px_ext = {1'b0, bus.pixelX};
   assign py_ext = {1'b0, bus.pixelY};

   // NOTE: every variable written in always_comb gets a value on every path
   // (here via the defaults at the top); a missed path would infer a latch.
   always_comb begin
      in_box  = 1'b0;
      visible = 1'b0;
      deb_inc = deb_cnt;

      in_box = (px_ext >= X_LO) && (px_ext < X_HI) &&
               (py_ext >= Y_LO) && (py_ext < Y_HI);

      unique case (state)
         WAIT_RELEASE,
         TITLE:   visible = blink_phase;
         CONFIRM: visible = 1'b1;
         PLAY:    visible = 1'b0;
      endcase

      // Saturating step of the debounce run length.
      if (deb_cnt != DEB_DONE) begin
         deb_inc = deb_cnt + 1'b1;
      end
   end

   assign shown = in_box && visible;

   // ------------------------------------------------------------------------
   // Sequencer, counters and registered outputs
   // ------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments only, so every
   // right-hand side below reads the value from before this clock edge, and
   // a later assignment to the same register in this block overrides an
   // earlier default (used for startGame).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state               <= WAIT_RELEASE;
         blink_phase         <= 1'b1;
         blink_cnt           <= '0;
         deb_cnt             <= '0;
         conf_cnt            <= '0;
         bus.InsideRectangle <= 1'b0;
         bus.offsetX         <= '0;
         bus.offsetY         <= '0;
         bus.startGame       <= 1'b0;
         bus.titleActive     <= 1'b1;
      end else begin
         // Geometry pipeline: describes the pixel presented this cycle,
         // using the visibility in force before any state change.
         bus.InsideRectangle <= shown;
         bus.offsetX         <= shown ? (bus.pixelX - X_ORG) : '0;
         bus.offsetY         <= shown ? (bus.pixelY - Y_ORG) : '0;

         // Pulse output; only the CONFIRM -> PLAY step raises it.
         bus.startGame <= 1'b0;

         if ((state == PLAY) && bus.gameOver) begin
            // gameOver takes priority over a coincident startOfFrame; the
            // title screen restarts exactly as it does out of reset.
            state           <= WAIT_RELEASE;
            deb_cnt         <= '0;
            blink_phase     <= 1'b1;
            blink_cnt       <= '0;
            bus.titleActive <= 1'b1;
         end else if (bus.startOfFrame) begin
            // Blink runs in every state; it only matters while visible
            // follows blink_phase, but keeping it free-running keeps the
            // cadence independent of key activity.
            if (blink_cnt == BLINK_LAST) begin
               blink_cnt   <= '0;
               blink_phase <= ~blink_phase;
            end else begin
               blink_cnt <= blink_cnt + 1'b1;
            end

            unique case (state)
               WAIT_RELEASE: begin
                  if (bus.enterKey) begin
                     deb_cnt <= '0;
                  end else if (deb_inc == DEB_DONE) begin
                     state   <= TITLE;
                     deb_cnt <= '0;
                  end else begin
                     deb_cnt <= deb_inc;
                  end
               end

               TITLE: begin
                  if (!bus.enterKey) begin
                     deb_cnt <= '0;
                  end else if (deb_inc == DEB_DONE) begin
                     state    <= CONFIRM;
                     deb_cnt  <= '0;
                     conf_cnt <= '0;
                  end else begin
                     deb_cnt <= deb_inc;
                  end
               end

               CONFIRM: begin
                  // Compare before incrementing: CONFIRM_FRAMES frames are
                  // spent here, the last one moving to PLAY.
                  if (conf_cnt == CONF_LAST) begin
                     state           <= PLAY;
                     bus.startGame   <= 1'b1;
                     bus.titleActive <= 1'b0;
                  end else begin
                     conf_cnt <= conf_cnt + 1'b1;
                  end
               end

               PLAY: ;
            endcase
         end
      end
   end

endmodule
